uart_tx_fifo: RTL

Buffered UART transmitter that returns bytes (SD read data, status) from the design to the PC over an 8N1 serial line. It is the return path for the existing PC-to-design UART receive path and uses the same bit timing: 50 MHz system clock, 9600 baud, LSB first. Producers push bytes into an internal FIFO. The block serialises them back to back with no idle gap while data remains.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_fifo.sv | 64 ++++++
 rtl/uart_tx_fifo.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, FSM state type and bit-timing helper
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Integer divide: no fractional-baud correction on either direction of the link.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered count/full/empty and show-ahead read data
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,      // synchronous, active-high
    input  logic                       wr_en,    // push when not full
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,    // pop when not empty
    output logic [WIDTH-1:0]           rd_data,  // head entry, valid whenever !empty
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Both qualifiers use start-of-cycle flags, so a push into a full FIFO is
    // refused even when a pop frees a slot in the same cycle.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10: begin
                    count <= count + CW'(1);
                    full  <= (count == CW'(DEPTH - 1));
                    empty <= 1'b0;
                end
                2'b01: begin
                    count <= count - CW'(1);
                    full  <= 1'b0;
                    empty <= (count == CW'(1));
                end
                default: ;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter, back-to-back frames from an internal FIFO
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,       // synchronous, active-high
    input  logic                       wr_en,     // push wr_data this cycle
    input  logic [UART_DATA_W-1:0]     wr_data,
    output logic                       full,      // FIFO holds DEPTH bytes
    output logic                       overflow,  // one-cycle pulse: byte dropped on full
    output logic [$clog2(DEPTH+1)-1:0] count,     // bytes queued, excluding the one on the wire
    output logic                       busy,      // frame in progress
    output logic                       tx         // serial line, idle high
);

    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int TW  = $clog2(CPB);

    uart_state_t            state;
    uart_state_t            state_d;
    logic [TW-1:0]          timer;
    logic [TW-1:0]          timer_d;
    logic [2:0]             bit_idx;
    logic [2:0]             bit_idx_d;
    logic [UART_DATA_W-1:0] shift;
    logic [UART_DATA_W-1:0] shift_d;
    logic [UART_DATA_W-1:0] fifo_data;
    logic                   tx_d;
    logic                   pop;
    logic                   fifo_empty;
    logic                   bit_done;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .full    (full),
        .empty   (fifo_empty),
        .count   (count)
    );

    assign bit_done = (timer == TW'(CPB - 1));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state    <= state_d;
            timer    <= timer_d;
            bit_idx  <= bit_idx_d;
            shift    <= shift_d;
            tx       <= tx_d;
            overflow <= wr_en && full;
        end
    end

    // tx_d is the line level for the next cycle, so every transition is
    // decided one cycle ahead and tx stays a plain flop.
    always_comb begin
        state_d   = state;
        timer_d   = timer;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        tx_d      = tx;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                tx_d    = 1'b1;
                timer_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_data;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    tx_d      = shift[0];
                    state_d   = DATA;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    timer_d = '0;
                    shift_d = shift >> 1;
                    if (bit_idx == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                        tx_d      = shift[1];
                    end
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    timer_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_data;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
